// File: rtl/mem_seq_pkg.sv
// ============================================================================
// Module      : mem_seq_pkg
// Description : Shared state encoding, default widths and helpers for the
//               data-memory access sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int DEFAULT_ADDR_W         = 32;
    localparam int DEFAULT_DATA_W         = 32;
    localparam int DEFAULT_TIMEOUT_CYCLES = 255;
    localparam int DEFAULT_CNT_W          = 32;

    // Width needed to hold values 0..n
    function automatic int ctr_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_timeout_ctr.sv
// ============================================================================
// Module      : mem_timeout_ctr
// Description : ACCESS-cycle counter; tc_o flags the final permitted cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_timeout_ctr
    import mem_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int            W    = ctr_width(TIMEOUT_CYCLES);
    localparam logic [W-1:0]  LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Asserted during the TIMEOUT_CYCLES-th ACCESS cycle
    assign tc_o = en_i & (cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/mem_access_sequencer.sv
// ============================================================================
// Module      : mem_access_sequencer
// Description : Sequences the EX/MEM data-memory access over a req/ready
//               handshake and stalls the pipeline until it completes.
//               Optional access timeout enabled by macro MEM_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_sequencer
    import mem_seq_pkg::*;
#(
    parameter int ADDR_W         = DEFAULT_ADDR_W,
    parameter int DATA_W         = DEFAULT_DATA_W,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              Stall,
    output logic [DATA_W-1:0] LoadData,
    output logic              LoadValid,
    output logic [CNT_W-1:0]  stall_count,
    output logic              bus_error
);

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] load_data_q, load_data_d;
    logic              load_valid_q, load_valid_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              acc;

    assign acc = MemRead | MemWrite;

`ifdef MEM_TIMEOUT_EN
    logic bus_error_q, bus_error_d;
    logic tmo_clr, tmo_en, tmo_tc;

    assign tmo_clr = (state_q == IDLE) & acc;
    assign tmo_en  = (state_q == ACCESS);

    mem_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (tmo_clr),
        .en_i  (tmo_en),
        .tc_o  (tmo_tc)
    );
`endif

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        Stall        = 1'b0;
`ifdef MEM_TIMEOUT_EN
        bus_error_d  = bus_error_q;
`endif
        case (state_q)
            IDLE: begin
                if (acc) begin
                    Stall     = 1'b1;
                    mem_req_d = 1'b1;
                    mem_we_d  = MemWrite;
                    addr_d    = ALUResult;
                    wdata_d   = WriteData;
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                Stall = 1'b1;
                if (mem_ready) begin
                    mem_req_d    = 1'b0;
                    load_valid_d = ~mem_we_q;
                    if (!mem_we_q) begin
                        load_data_d = mem_rdata;
                    end
                    state_d = DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (tmo_tc) begin
                    mem_req_d   = 1'b0;
                    load_data_d = '0;
                    bus_error_d = 1'b1;
                    state_d     = DONE;
                end
`endif
            end
            DONE: begin
                // EX/MEM advances on this edge; the instruction is not re-issued
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        stall_cnt_d = stall_cnt_q;
        if (Stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_error_q <= 1'b0;
        end else begin
            bus_error_q <= bus_error_d;
        end
    end

    assign bus_error = bus_error_q;
`else
    assign bus_error = 1'b0;
`endif

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign LoadData    = load_data_q;
    assign LoadValid   = load_valid_q;
    assign stall_count = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_sequencer.sv
// ============================================================================
// Module      : tb_mem_access_sequencer
// Description : Self-checking bench for mem_access_sequencer (directed and
//               randomized transactions against a transaction-level model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead, MemWrite, mem_ready;
    logic [31:0] ALUResult, WriteData, mem_rdata;
    logic        mem_req, mem_we, Stall, LoadValid, bus_error;
    logic [31:0] mem_addr, mem_wdata, LoadData, stall_count;

    int          vectors    = 0;
    int          miscompares = 0;
    logic [31:0] exp_ld     = '0;
    int          exp_stall  = 0;
    logic        exp_berr   = 1'b0;

    always #5 clk = ~clk;

    mem_access_sequencer #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (8),
        .CNT_W          (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .ALUResult   (ALUResult),
        .WriteData   (WriteData),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .Stall       (Stall),
        .LoadData    (LoadData),
        .LoadValid   (LoadValid),
        .stall_count (stall_count),
        .bus_error   (bus_error)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One instruction held in EX/MEM until its DONE cycle; memory answers after 'delay' wait cycles
    task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata, input int delay);
        int   stalls = 0, reqs = 0, rises = 0, lv = 0;
        bit   stable = 1'b1;
        bit   prev_req;
        bit   is_load = rd && !wr;
        int   ncyc = 3 + delay;
        prev_req = mem_req;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            MemRead   = rd;
            MemWrite  = wr;
            ALUResult = addr;
            WriteData = wdata;
            if (c == 1 + delay) begin
                mem_ready = 1'b1;
                mem_rdata = rdata;
            end else if (c >= 1 && c <= delay) begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end
            #1;
            if (Stall) stalls++;
            if (mem_req) begin
                reqs++;
                if (!prev_req) rises++;
                if (mem_addr !== addr || mem_wdata !== wdata || mem_we !== wr) stable = 1'b0;
            end
            prev_req = mem_req;
            if (LoadValid) lv++;
            if (c == ncyc - 1) begin
                exp_stall += 2 + delay;
                if (is_load) exp_ld = rdata;
                check("done_stall", {63'd0, Stall}, 64'd0);
                check("done_loadvalid", {63'd0, LoadValid}, {63'd0, is_load});
                check("loaddata", {32'd0, LoadData}, {32'd0, exp_ld});
                check("stall_count", {32'd0, stall_count}, 64'(exp_stall));
                check("bus_error", {63'd0, bus_error}, {63'd0, exp_berr});
            end
        end
        check("stall_cycles", 64'(stalls), 64'(2 + delay));
        check("req_cycles", 64'(reqs), 64'(1 + delay));
        check("req_issues", 64'(rises), 64'd1);
        check("req_fields_stable", {63'd0, stable}, 64'd1);
        check("loadvalid_pulses", 64'(lv), is_load ? 64'd1 : 64'd0);
    endtask

    task automatic idle_gap(input int n);
        bit bad = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            MemRead   = 1'b0;
            MemWrite  = 1'b0;
            ALUResult = $urandom;
            WriteData = $urandom;
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            #1;
            if (Stall || mem_req || LoadValid) bad = 1'b1;
        end
        if (n > 0) check("idle_quiet", {63'd0, bad}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; mem_ready = 1'b0;
        ALUResult = '0; WriteData = '0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_mem_req", {63'd0, mem_req}, 64'd0);
        check("rst_mem_we", {63'd0, mem_we}, 64'd0);
        check("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
        check("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
        check("rst_loaddata", {32'd0, LoadData}, 64'd0);
        check("rst_loadvalid", {63'd0, LoadValid}, 64'd0);
        check("rst_stall_count", {32'd0, stall_count}, 64'd0);
        check("rst_bus_error", {63'd0, bus_error}, 64'd0);
        check("rst_stall", {63'd0, Stall}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed: fast load, slow store, back-to-back, read+write collision
        run_txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 0);
        idle_gap(2);
        run_txn(1'b0, 1'b1, 32'h0000_0080, 32'h1234_5678, 32'hFFFF_0000, 4);
        run_txn(1'b1, 1'b0, 32'h0000_0100, 32'hAAAA_5555, 32'hCAFE_F00D, 0);
        run_txn(1'b0, 1'b1, 32'h0000_0104, 32'h0BAD_F00D, 32'h1111_1111, 0);
        run_txn(1'b1, 1'b1, 32'h0000_0200, 32'h7777_8888, 32'h2222_2222, 1);
        idle_gap(1);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            int  kind = $urandom_range(0, 2);
            bit  rd   = (kind != 1);
            bit  wr   = (kind != 0);
            run_txn(rd, wr, $urandom, $urandom, $urandom, $urandom_range(0, 5));
            idle_gap($urandom_range(0, 2));
        end

        // Reset during the second ACCESS cycle abandons the transaction
        @(negedge clk);
        MemRead = 1'b1; MemWrite = 1'b0; ALUResult = 32'h300; mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; MemRead = 1'b0;
        exp_stall = 0; exp_ld = '0; exp_berr = 1'b0;
        #1;
        check("rstmid_mem_req", {63'd0, mem_req}, 64'd0);
        check("rstmid_stall", {63'd0, Stall}, 64'd0);
        check("rstmid_stall_count", {32'd0, stall_count}, 64'd0);
        check("rstmid_loadvalid", {63'd0, LoadValid}, 64'd0);
        run_txn(1'b1, 1'b0, 32'h0000_0044, 32'h0, 32'h5A5A_A5A5, 2);

`ifdef MEM_TIMEOUT_EN
        begin
            int reqs = 0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                MemRead = 1'b1; MemWrite = 1'b0; ALUResult = 32'h400;
                mem_ready = 1'b0; mem_rdata = $urandom;
                #1;
                if (mem_req) reqs++;
                if (c == 9) begin
                    exp_stall += 9; exp_ld = '0; exp_berr = 1'b1;
                    check("tmo_stall", {63'd0, Stall}, 64'd0);
                    check("tmo_bus_error", {63'd0, bus_error}, 64'd1);
                    check("tmo_loaddata", {32'd0, LoadData}, 64'd0);
                    check("tmo_loadvalid", {63'd0, LoadValid}, 64'd0);
                    check("tmo_stall_count", {32'd0, stall_count}, 64'(exp_stall));
                end
            end
            check("tmo_access_cycles", 64'(reqs), 64'd8);
            run_txn(1'b0, 1'b1, 32'h0000_0408, 32'h9999_0000, 32'h0, 1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
